dram_port_master: RTL and testbench
===================================

// Module: dram_port_master
// PURPOSE
//  Core-side initiator for one DRAM port (we/addr/wdata out, rdata in, 1-cycle synchronous read).
//  Accepts single or burst load/store requests from a core over a valid/ready handshake.
//  Sequences incrementing DRAM addresses, streams write data in and read data back.
//  One instance per core, wired to that core's slice of the DRAM multi-port bus.
// PARAMETERS
//  ADDR_W  16  DRAM address width
//  DATA_W  16  DRAM word width
//  LEN_W   8   burst length field width; a burst is req_len+1 words (1..2^LEN_W)
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       request accepted when req_valid && req_ready
//  req_write  in   1       1 = burst write, 0 = burst read
//  req_addr   in   ADDR_W  base word address
//  req_len    in   LEN_W   words minus one
//  wr_valid   in   1       write beat data present
//  wr_ready   out  1       write beat consumed when wr_valid && wr_ready
//  wr_data    in   DATA_W  write beat data
//  rd_valid   out  1       read word valid (no backpressure; core must take it)
//  rd_data    out  DATA_W  read word
//  rd_last    out  1       qualifies final word of a read burst
//  busy       out  1       state != IDLE
//  done       out  1       one-cycle pulse, burst complete
//  mem_we     out  1       to DRAM write_en
//  mem_addr   out  ADDR_W  to DRAM addr
//  mem_wdata  out  DATA_W  to DRAM data_in
//  mem_rdata  in   DATA_W  from DRAM data_out (valid cycle after a read address is presented)
// BEHAVIOUR
//  FSM IDLE -> READ | WRITE -> DONE -> IDLE. Regs: state, base_q, len_q, cnt (LEN_W), write_q, rd_pend.
//  Reset: state=IDLE, cnt=0, rd_pend=0; so req_ready=1, wr_ready=0, rd_valid=0, rd_last=0, busy=0,
//   done=0, mem_we=0, mem_addr=0, mem_wdata=0.
//  IDLE: req_ready=1; on accept latch addr/len/write, cnt=0, next state READ or WRITE. mem_* = 0.
//  mem_addr = base_q + cnt, mod 2^ADDR_W (0xFFFF wraps to 0x0000); no range check.
//  READ: mem_we=0, one address per cycle; cnt++ each cycle; rd_pend<=1.
//   When cnt==len_q -> DONE. rd_valid=rd_pend, rd_data=mem_rdata (combinational pass-through).
//   Accept at T: addresses at T+1..T+1+L, data at T+2..T+2+L, rd_last and done at T+2+L.
//  WRITE: wr_ready=1; mem_we=wr_valid, mem_wdata=wr_data. cnt++ only on a beat.
//   wr_valid gaps stall (mem_we=0, address held). Beat with cnt==len_q -> DONE.
//  DONE: exactly one cycle. done=1, req_ready=0, mem_we=0. Read: rd_valid=1, rd_last=1 (final word).
//   Then IDLE; next request accepted earliest the cycle after DONE.
//  req_valid outside IDLE is ignored (req_ready=0); request fields may change freely.
//  rst mid-burst: IDLE on next edge. In-flight read word dropped (rd_valid=0). No done pulse.
//   Partial writes already issued stay in DRAM.
// STRUCTURE
//  Shared include dram_defs.vh: NUM_C, ADDR_W/DATA_W/LEN_W defaults, state encodings
//   (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3).
//  Single module; no sub-module warranted. Top instantiates NUM_C copies, packs mem_* into the DRAM bus.
// TESTING (bench: this block + behavioural 1-cycle-read DRAM model)
//  1 Reset: hold rst 2 cycles -> outputs exactly reset values; release -> req_ready=1.
//  2 Write len=0 addr=10 data=85, then read len=0 addr=10 -> rd_data=85, rd_valid=rd_last=done=1
//    at accept+2.
//  3 Write len=3 addr=100 data 1,2,3,4 with wr_valid low 2 cycles mid-burst -> mem_we only on beats,
//    addr 100..103. Read back -> 1,2,3,4 on 4 consecutive cycles, rd_last on 4.
//  4 Read len=2 addr=0xFFFE -> mem_addr 0xFFFE,0xFFFF,0x0000.
//  5 rst after 2nd address of len=7 read -> IDLE next cycle, rd_valid=0, no done; new read len=0 ok.
//  6 req_valid held during len=255 write -> req_ready=0 throughout, 256 beats, one done,
//    then accept one cycle after DONE.

Source files
------------

// File: rtl/dram_port_master_pkg.sv
// dram_port_master_pkg: shared widths, port count and FSM state encoding for the DRAM port master
package dram_port_master_pkg;

    localparam int NUM_C      = 4;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dram_port_master_if.sv
// dram_port_master_if: core-side request, write-beat and read-return channels of one DRAM port
interface dram_port_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport master (
        output req_valid, req_write, req_addr, req_len, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_data, rd_last
    );

endinterface

// File: rtl/dram_port_master.sv
// dram_port_master: sequences single/burst loads and stores from one core onto a 1-cycle-read DRAM port
module dram_port_master
    import dram_port_master_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    dram_port_master_if.slave core,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              write_q;
    logic              rd_pend_q;
    logic              last;
    logic              active;

    assign last   = cnt_q == len_q;
    assign active = (state_q == READ) || (state_q == WRITE);

    // Burst FSM: latch the request, walk cnt per address (reads) or per accepted beat (writes)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= state_q == READ;
            case (state_q)
                IDLE: if (core.req_valid) begin
                    base_q  <= core.req_addr;
                    len_q   <= core.req_len;
                    write_q <= core.req_write;
                    cnt_q   <= '0;
                    state_q <= core.req_write ? WRITE : READ;
                end
                READ: begin
                    cnt_q <= cnt_q + LEN_W'(1);
                    if (last) state_q <= DONE;
                end
                WRITE: if (core.wr_valid) begin
                    cnt_q <= cnt_q + LEN_W'(1);
                    if (last) state_q <= DONE;
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end

    assign core.req_ready = state_q == IDLE;
    assign core.wr_ready  = state_q == WRITE;
    assign core.rd_valid  = rd_pend_q;
    assign core.rd_data   = mem_rdata_i;
    assign core.rd_last   = (state_q == DONE) && !write_q;

    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign mem_we_o    = (state_q == WRITE) && core.wr_valid;
    assign mem_addr_o  = active ? base_q + ADDR_W'(cnt_q) : '0;
    assign mem_wdata_o = (state_q == WRITE) ? core.wr_data : '0;

endmodule

// File: tb/tb_dram_port_master.sv
// tb_dram_port_master: directed vector table, corner sequences and random bursts against a shadow-memory model
module tb_dram_port_master;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [15:0] d0;
        int          gap_at;
        int          gap_n;
        logic [15:0] exp_first;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy, done, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    bit   [15:0] dram    [0:65535];
    bit   [15:0] ref_mem [0:65535];
    int          n_chk  = 0;
    int          n_fail = 0;

    dram_port_master_if #(.ADDR_W(16), .DATA_W(16), .LEN_W(8)) bus ();

    dram_port_master #(.ADDR_W(16), .DATA_W(16), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .core       (bus),
        .busy_o     (busy),
        .done_o     (done),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // DRAM with 1-cycle synchronous read
    always @(posedge clk) begin
        if (mem_we) dram[mem_addr] <= mem_wdata;
        mem_rdata <= dram[mem_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic jitter(input bit hold);
        if (hold) begin
            bus.req_write = 1'($urandom);
            bus.req_addr  = 16'($urandom);
            bus.req_len   = 8'($urandom);
        end
    endtask

    // One burst starting in an IDLE cycle (called at posedge+1); returns at posedge+1 of the following IDLE cycle
    task automatic run_burst(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                             input logic [15:0] d0, input int gap_at, input int gap_n,
                             input bit rnd, input bit hold, output logic [15:0] first_rd);
        logic [15:0] wq[$];
        logic [15:0] ea;
        int          b, g, k;
        bit          pres;
        first_rd = '0;
        for (int i = 0; i <= int'(len); i++) wq.push_back(rnd ? 16'($urandom) : d0 + 16'(i));
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 16'($urandom);
        @(negedge clk);
        chk("idle_req_ready", 32'(bus.req_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_mem_we", 32'(mem_we), 0);
        chk("idle_mem_addr", 32'(mem_addr), 0);
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
        if (wr) begin
            b = 0; g = 0; k = 0;
            while (b <= int'(len) && k < int'(len) + 64) begin
                jitter(hold);
                pres = rnd ? ($urandom_range(0, 3) != 0) : !(b == gap_at && g < gap_n);
                if (!pres) g++;
                bus.wr_valid = pres;
                bus.wr_data  = pres ? wq[b] : 16'($urandom);
                ea = addr + 16'(b);
                @(negedge clk);
                chk("wr_ready", 32'(bus.wr_ready), 1);
                chk("wr_req_ready", 32'(bus.req_ready), 0);
                chk("wr_done", 32'(done), 0);
                chk("wr_mem_we", 32'(mem_we), 32'(pres));
                if (pres) begin
                    chk("wr_mem_addr", 32'(mem_addr), 32'(ea));
                    chk("wr_mem_wdata", 32'(mem_wdata), 32'(wq[b]));
                end
                @(posedge clk); #1;
                if (pres) begin
                    ref_mem[ea] = wq[b];
                    b++;
                end
                k++;
            end
            chk("wr_beats", b, int'(len) + 1);
            bus.wr_valid = 1'b0;
            jitter(hold);
            @(negedge clk);
            chk("wdone_done", 32'(done), 1);
            chk("wdone_busy", 32'(busy), 1);
            chk("wdone_req_ready", 32'(bus.req_ready), 0);
            chk("wdone_mem_we", 32'(mem_we), 0);
            chk("wdone_rd_valid", 32'(bus.rd_valid), 0);
            chk("wdone_rd_last", 32'(bus.rd_last), 0);
            @(posedge clk); #1;
        end else begin
            for (int k2 = 1; k2 <= int'(len) + 2; k2++) begin
                jitter(hold);
                @(negedge clk);
                chk("rd_req_ready", 32'(bus.req_ready), 0);
                chk("rd_busy", 32'(busy), 1);
                chk("rd_mem_we", 32'(mem_we), 0);
                if (k2 <= int'(len) + 1) begin
                    ea = addr + 16'(k2 - 1);
                    chk("rd_mem_addr", 32'(mem_addr), 32'(ea));
                end
                chk("rd_valid", 32'(bus.rd_valid), 32'(k2 >= 2));
                if (k2 >= 2) begin
                    ea = addr + 16'(k2 - 2);
                    chk("rd_data", 32'(bus.rd_data), 32'(ref_mem[ea]));
                    if (k2 == 2) first_rd = bus.rd_data;
                end
                chk("rd_last", 32'(bus.rd_last), 32'(k2 == int'(len) + 2));
                chk("rd_done", 32'(done), 32'(k2 == int'(len) + 2));
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        vec_t        vt [7];
        logic [15:0] fr;
        logic [15:0] ra;
        vt[0] = '{1'b1, 16'd10,    8'd0, 16'd85,     -1, 0, 16'd0};
        vt[1] = '{1'b0, 16'd10,    8'd0, 16'd0,      -1, 0, 16'd85};
        vt[2] = '{1'b1, 16'd100,   8'd3, 16'd1,       2, 2, 16'd0};
        vt[3] = '{1'b0, 16'd100,   8'd3, 16'd0,      -1, 0, 16'd1};
        vt[4] = '{1'b1, 16'hFFFE,  8'd2, 16'h0700,   -1, 0, 16'd0};
        vt[5] = '{1'b0, 16'hFFFE,  8'd2, 16'd0,      -1, 0, 16'h0700};
        vt[6] = '{1'b0, 16'h0000,  8'd0, 16'd0,      -1, 0, 16'h0702};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h1234;
        bus.req_len   = 8'd5;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 16'hBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_wr_ready", 32'(bus.wr_ready), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_rd_last", 32'(bus.rd_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("rel_req_ready", 32'(bus.req_ready), 1);
        chk("rel_busy", 32'(busy), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_burst(vt[i].wr, vt[i].addr, vt[i].len, vt[i].d0, vt[i].gap_at, vt[i].gap_n, 1'b0, 1'b0, fr);
            if (!vt[i].wr) chk($sformatf("vec%0d_first_rd", i), 32'(fr), 32'(vt[i].exp_first));
        end

        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0300;
        bus.req_len   = 8'd7;
        @(negedge clk);
        chk("mid_rst_accept", 32'(bus.req_ready), 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_addr0", 32'(mem_addr), 32'h0300);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_addr1", 32'(mem_addr), 32'h0301);
        chk("mid_rst_rdv_pre", 32'(bus.rd_valid), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_busy", 32'(busy), 0);
            chk("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
            chk("mid_rst_done", 32'(done), 0);
            chk("mid_rst_req_ready", 32'(bus.req_ready), 1);
            @(posedge clk); #1;
        end
        run_burst(1'b0, 16'd10, 8'd0, 16'd0, -1, 0, 1'b0, 1'b0, fr);
        chk("post_rst_read", 32'(fr), 32'd85);

        run_burst(1'b1, 16'h2000, 8'd255, 16'h5000, -1, 0, 1'b0, 1'b1, fr);
        run_burst(1'b0, 16'h20FF, 8'd0, 16'd0, -1, 0, 1'b0, 1'b0, fr);
        chk("long_burst_last_word", 32'(fr), 32'h50FF);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 511));
            run_burst(1'($urandom_range(0, 1)), ra, 8'($urandom_range(0, 15)), 16'd0, -1, 0, 1'b1, 1'b0, fr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
